mem_port_arbiter: RTL

// - Shares the single-port processor memory between the CPU control path (fetch/LDA/STA/LDAR) and a host/debug

---
 rtl/qtcore_mem_pkg.sv | 14 +
 rtl/arb_starve_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/qtcore_mem_pkg.sv
// Shared types for the processor memory port arbiter.
// Arbiter state encoding and memory owner codes.
package qtcore_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } arb_state_t;

  localparam logic OWNER_CPU  = 1'b0;
  localparam logic OWNER_HOST = 1'b1;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive CPU grants made while the host waits.
// Ports: clk, rst_n, inc, clr -> limit_hit (count == LIMIT).
module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != LIM) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign limit_hit = (cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port sync memory between CPU and host loader.
// Ports: cpu_*/host_* request ports, host_lock, mem_* macro side.
module mem_port_arbiter
  import qtcore_mem_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  input  logic              host_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state, nstate;

  logic              owner_q;
  logic              we_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic              limit_hit;
  logic              idle, resp;
  logic              host_win, cpu_win;
  logic              grant_cpu, grant_host;
  logic              st_inc, st_clr;

  assign idle = (state == IDLE);
  assign resp = (state == RESP);

  // Host wins under lock, when alone, or once the CPU
  // has used up its consecutive-grant allowance.
  assign host_win   = host_req &
                      (host_lock | ~cpu_req | limit_hit);
  assign cpu_win    = cpu_req & ~host_lock & ~host_win;
  assign grant_cpu  = idle & cpu_win;
  assign grant_host = idle & host_win;

  assign st_inc = grant_cpu & host_req;
  assign st_clr = idle & (grant_host | ~host_req);

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (st_inc),
    .clr      (st_clr),
    .limit_hit(limit_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (grant_cpu || grant_host) nstate = ACCESS;
      end
      ACCESS:  nstate = RESP;
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= OWNER_CPU;
      we_q      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_host) begin
      owner_q   <= OWNER_HOST;
      we_q      <= host_we;
      mem_en    <= 1'b1;
      mem_we    <= host_we;
      mem_addr  <= host_addr;
      mem_wdata <= host_wdata;
    end else if (grant_cpu) begin
      owner_q   <= OWNER_CPU;
      we_q      <= cpu_we;
      mem_en    <= 1'b1;
      mem_we    <= cpu_we;
      mem_addr  <= cpu_addr;
      mem_wdata <= cpu_wdata;
    end else if (state == ACCESS) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // Memory data only arrives in RESP, so the ack cycle
  // forwards it and the register keeps it afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else if (resp && !we_q) begin
      if (owner_q == OWNER_CPU) cpu_rdata_q  <= mem_rdata;
      else                      host_rdata_q <= mem_rdata;
    end
  end

  assign cpu_ack  = resp & (owner_q == OWNER_CPU);
  assign host_ack = resp & (owner_q == OWNER_HOST);

  assign cpu_rdata  = (cpu_ack & ~we_q) ? mem_rdata
                                        : cpu_rdata_q;
  assign host_rdata = (host_ack & ~we_q) ? mem_rdata
                                         : host_rdata_q;

  assign cpu_stall = host_lock | (cpu_req & ~cpu_ack);

endmodule
